// File: rtl/demo_streaming_0_cpu_cpu_debug_ocimem_arbiter.sv
// rtl/demo_streaming_0_cpu_cpu_debug_ocimem_arbiter.sv - debug RAM arbiter between JTAG monitor and CPU slave
module demo_streaming_0_cpu_cpu_debug_ocimem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_waitrequest,
  output logic [31:0]       cpu_readdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_RDW} state_t;

  state_t              state_q, state_d;
  logic                jtag_pend_q, jtag_pend_d;
  logic                jtag_we_q, jtag_we_d;
  logic [ADDR_W-1:0]   jtag_addr_q, jtag_addr_d;
  logic [ADDR_W-1:0]   jtag_req_addr_q, jtag_req_addr_d;
  logic [31:0]         jtag_wdata_q, jtag_wdata_d;
  logic                last_jtag_q, last_jtag_d;
  logic                owner_jtag_q, owner_jtag_d;
  logic                acc_we_q, acc_we_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [31:0]         ram_wdata_q, ram_wdata_d;
  logic [31:0]         mon_q, mon_d;
  logic                ready_q;
  logic                error_q, error_d;
  logic                grant_jtag, grant_cpu, cpu_granted;
  logic [ADDR_W-1:0]   jdo_addr;
  logic                unused_jdo;

  assign jdo_addr   = jdo[ADDR_W+9:10];
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // Round-robin: JTAG wins a tie unless it was the last one served.
  assign grant_jtag = jtag_pend_q & (~cpu_req | ~last_jtag_q);
  assign grant_cpu  = cpu_req & ~grant_jtag;

  always_comb begin
    state_d      = state_q;
    last_jtag_d  = last_jtag_q;
    owner_jtag_d = owner_jtag_q;
    acc_we_d     = acc_we_q;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = '0;
    ram_wdata_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_jtag || grant_cpu) begin
          state_d      = S_ACC;
          owner_jtag_d = grant_jtag;
          last_jtag_d  = grant_jtag;
          ram_en_d     = 1'b1;
          if (grant_jtag) begin
            ram_we_d    = jtag_we_q;
            ram_addr_d  = jtag_req_addr_q;
            ram_wdata_d = jtag_we_q ? jtag_wdata_q : 32'h0;
          end else begin
            ram_we_d    = cpu_write;
            ram_addr_d  = cpu_addr;
            ram_wdata_d = cpu_write ? cpu_wdata : 32'h0;
          end
          acc_we_d = ram_we_d;
        end
      end
      S_ACC:   state_d = acc_we_q ? S_IDLE : S_RDW;
      S_RDW:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Commands are only taken while the one-deep slot is empty.
  always_comb begin
    jtag_pend_d     = jtag_pend_q;
    jtag_we_d       = jtag_we_q;
    jtag_addr_d     = jtag_addr_q;
    jtag_req_addr_d = jtag_req_addr_q;
    jtag_wdata_d    = jtag_wdata_q;
    error_d         = error_q;
    mon_d           = mon_q;
    if (jtag_pend_q) begin
      if (take_action_ocimem_a || take_no_action_ocimem_a || take_action_ocimem_b)
        error_d = 1'b1;
      if (owner_jtag_q && ((state_q == S_ACC && acc_we_q) || state_q == S_RDW))
        jtag_pend_d = 1'b0;
    end else if (take_action_ocimem_a) begin
      jtag_addr_d = jdo_addr;
      if (jdo[25])
        error_d = 1'b0;
      if (jdo[34]) begin
        jtag_pend_d     = 1'b1;
        jtag_we_d       = 1'b0;
        jtag_req_addr_d = jdo_addr;
        jtag_addr_d     = jdo_addr + ADDR_W'(1);
      end
    end else if (take_no_action_ocimem_a) begin
      jtag_pend_d     = 1'b1;
      jtag_we_d       = 1'b0;
      jtag_req_addr_d = jtag_addr_q;
      jtag_addr_d     = jtag_addr_q + ADDR_W'(1);
    end else if (take_action_ocimem_b) begin
      jtag_pend_d     = 1'b1;
      jtag_we_d       = 1'b1;
      jtag_req_addr_d = jtag_addr_q;
      jtag_wdata_d    = jdo[34:3];
      jtag_addr_d     = jtag_addr_q + ADDR_W'(1);
    end
    if (state_q == S_RDW && owner_jtag_q)
      mon_d = ram_rdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      jtag_pend_q     <= 1'b0;
      jtag_we_q       <= 1'b0;
      jtag_addr_q     <= '0;
      jtag_req_addr_q <= '0;
      jtag_wdata_q    <= '0;
      last_jtag_q     <= 1'b0;
      owner_jtag_q    <= 1'b0;
      acc_we_q        <= 1'b0;
      ram_en_q        <= 1'b0;
      ram_we_q        <= 1'b0;
      ram_addr_q      <= '0;
      ram_wdata_q     <= '0;
      mon_q           <= '0;
      ready_q         <= 1'b1;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      jtag_pend_q     <= jtag_pend_d;
      jtag_we_q       <= jtag_we_d;
      jtag_addr_q     <= jtag_addr_d;
      jtag_req_addr_q <= jtag_req_addr_d;
      jtag_wdata_q    <= jtag_wdata_d;
      last_jtag_q     <= last_jtag_d;
      owner_jtag_q    <= owner_jtag_d;
      acc_we_q        <= acc_we_d;
      ram_en_q        <= ram_en_d;
      ram_we_q        <= ram_we_d;
      ram_addr_q      <= ram_addr_d;
      ram_wdata_q     <= ram_wdata_d;
      mon_q           <= mon_d;
      ready_q         <= ~jtag_pend_d;
      error_q         <= error_d;
    end
  end

  assign cpu_granted     = ~owner_jtag_q & (state_q != S_IDLE);
  assign cpu_waitrequest = cpu_req & ~(cpu_granted &
                           (((state_q == S_ACC) & cpu_write) | ((state_q == S_RDW) & ~cpu_write)));
  assign cpu_readdata    = (cpu_granted && state_q == S_RDW) ? ram_rdata : 32'h0;

  assign ram_en        = ram_en_q;
  assign ram_we        = ram_we_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign MonDReg       = mon_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

// File: tb/tb_demo_streaming_0_cpu_cpu_debug_ocimem_arbiter.sv
// tb/tb_demo_streaming_0_cpu_cpu_debug_ocimem_arbiter.sv - scoreboard bench for the debug RAM arbiter
module tb_demo_streaming_0_cpu_cpu_debug_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_write = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [40:0] exp_q [$];

  demo_streaming_0_cpu_cpu_debug_ocimem_arbiter #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .MonDReg(MonDReg), .monitor_ready(monitor_ready),
    .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  // Single-port RAM, one-cycle read latency; preload port for the bench.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every RAM strobe must match the oldest expected access.
  always @(negedge clk) begin
    if (ram_en === 1'b1) begin
      check("strobe_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        logic [40:0] e;
        e = exp_q.pop_front();
        check("strobe_we", ram_we, e[40]);
        check("strobe_addr", ram_addr, e[39:32]);
        if (e[40]) check("strobe_wdata", ram_wdata, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic we, input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back({we, a, d});
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask

  function automatic logic [37:0] j_addr(input logic [7:0] a, input logic rd, input logic clr);
    logic [37:0] v;
    v = '0;
    v[17:10] = a;
    v[34] = rd;
    v[25] = clr;
    return v;
  endfunction

  function automatic logic [37:0] j_data(input logic [31:0] d);
    logic [37:0] v;
    v = '0;
    v[34:3] = d;
    return v;
  endfunction

  // which: 0 = set-address, 1 = read-next, 2 = write
  task automatic pulse(input int which, input logic [37:0] d);
    jdo = d;
    take_action_ocimem_a    = (which == 0);
    take_no_action_ocimem_a = (which == 1);
    take_action_ocimem_b    = (which == 2);
    tick();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (monitor_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, monitor_ready, 1'b1);
    tick();
  endtask

  task automatic cpu_access(input string tag, input logic we, input logic [7:0] a,
                            input logic [31:0] d, output logic [31:0] rdata);
    int n;
    cpu_req = 1'b1; cpu_write = we; cpu_addr = a; cpu_wdata = d;
    n = 0;
    rdata = '0;
    forever begin
      @(negedge clk);
      n++;
      if (cpu_waitrequest === 1'b0 || n >= 50) break;
    end
    check(tag, cpu_waitrequest, 1'b0);
    rdata = cpu_readdata;
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({tag, "_ram_en"}, ram_en, 1'b0);
    check({tag, "_ram_addr"}, ram_addr, 8'h00);
    check({tag, "_ram_wdata"}, ram_wdata, 32'h0);
    check({tag, "_mondreg"}, MonDReg, 32'h0);
    check({tag, "_ready"}, monitor_ready, 1'b1);
    check({tag, "_error"}, monitor_error, 1'b0);
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    int wr_seen;

    do_reset("rst");
    preload(8'h10, 32'hDEADBEEF);
    preload(8'h11, 32'h11111111);
    preload(8'h00, 32'hCAFEF00D);
    preload(8'h01, 32'h11110001);
    preload(8'h02, 32'h22220002);
    preload(8'h05, 32'hA5A5A5A5);
    preload(8'h20, 32'h0);
    preload(8'h21, 32'h0);
    preload(8'h50, 32'h0);

    // Set-address with read, then read-next checks the post-increment.
    push(1'b0, 8'h10, 32'h0);
    pulse(0, j_addr(8'h10, 1'b1, 1'b0));
    check("setaddr_busy", monitor_ready, 1'b0);
    wait_ready("setaddr_ready");
    check("setaddr_mondreg", MonDReg, 32'hDEADBEEF);
    push(1'b0, 8'h11, 32'h0);
    pulse(1, '0);
    wait_ready("next_ready");
    check("next_mondreg", MonDReg, 32'h11111111);

    // Address wrap 0xFF -> 0x00.
    pulse(0, j_addr(8'hFF, 1'b0, 1'b0));
    push(1'b1, 8'hFF, 32'h12345678);
    pulse(2, j_data(32'h12345678));
    wait_ready("wrap_wr_ready");
    check("wrap_mem", mem[8'hFF], 32'h12345678);
    check("wr_keeps_mondreg", MonDReg, 32'h11111111);
    push(1'b0, 8'h00, 32'h0);
    pulse(1, '0);
    wait_ready("wrap_rd_ready");
    check("wrap_rd_mondreg", MonDReg, 32'hCAFEF00D);

    // Second write while pending is dropped and flags an error.
    pulse(0, j_addr(8'h20, 1'b0, 1'b0));
    push(1'b1, 8'h20, 32'h1);
    pulse(2, j_data(32'h1));
    pulse(2, j_data(32'h2));
    check("drop_error", monitor_error, 1'b1);
    wait_ready("drop_ready");
    check("drop_mem20", mem[8'h20], 32'h1);
    check("drop_mem21", mem[8'h21], 32'h0);
    check("drop_error_sticky", monitor_error, 1'b1);
    pulse(0, j_addr(8'h30, 1'b0, 1'b1));
    check("error_cleared", monitor_error, 1'b0);

    // Round-robin ties; fresh reset makes JTAG win the first one.
    do_reset("rst2");
    push(1'b0, 8'h00, 32'h0);
    push(1'b1, 8'h40, 32'h0000C0C0);
    pulse(1, '0);
    cpu_access("tie1_cpu", 1'b1, 8'h40, 32'h0000C0C0, rd);
    wait_ready("tie1_ready");
    check("tie1_mondreg", MonDReg, 32'hCAFEF00D);
    check("tie1_mem", mem[8'h40], 32'h0000C0C0);
    push(1'b0, 8'h01, 32'h0);
    pulse(1, '0);
    wait_ready("solo_ready");
    check("solo_mondreg", MonDReg, 32'h11110001);
    push(1'b1, 8'h41, 32'h0000C1C1);
    push(1'b0, 8'h02, 32'h0);
    pulse(1, '0);
    cpu_access("tie2_cpu", 1'b1, 8'h41, 32'h0000C1C1, rd);
    wait_ready("tie2_ready");
    check("tie2_mondreg", MonDReg, 32'h22220002);

    // Uncontended CPU read: waitrequest drops in the third cycle.
    push(1'b0, 8'h05, 32'h0);
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h05;
    @(negedge clk);
    check("rd_c1_wait", cpu_waitrequest, 1'b1);
    @(negedge clk);
    check("rd_c2_wait", cpu_waitrequest, 1'b1);
    check("rd_c2_data", cpu_readdata, 32'h0);
    @(negedge clk);
    check("rd_c3_wait", cpu_waitrequest, 1'b0);
    check("rd_c3_data", cpu_readdata, 32'hA5A5A5A5);
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    check("rd_after_data", cpu_readdata, 32'h0);

    // Reset asserted in the middle of an ACC cycle.
    push(1'b1, 8'h50, 32'h00005555);
    cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 8'h50; cpu_wdata = 32'h00005555;
    wr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_en === 1'b1) begin
        wr_seen = 1;
        break;
      end
    end
    check("midacc_strobe_seen", 64'(wr_seen), 64'd1);
    #2 reset_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    check("midacc_ram_en", ram_en, 1'b0);
    check("midacc_ram_we", ram_we, 1'b0);
    check("midacc_ram_addr", ram_addr, 8'h00);
    check("midacc_mondreg", MonDReg, 32'h0);
    check("midacc_ready", monitor_ready, 1'b1);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_c1_en", ram_en, 1'b0);
    @(negedge clk);
    check("post_rst_c2_en", ram_en, 1'b0);
    check("midacc_no_write", mem[8'h50], 32'h0);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
